// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// parameter defaults used by the arbiter and its sub-modules.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int NREQ_DEF        = 4;
    localparam int DATA_W_DEF      = 8;
    localparam int TIMEOUT_CYC_DEF = 0;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester at or after
// (last_grant + 1) mod NREQ, wrapping, wins.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last_grant,
    output logic            valid,
    output logic [GW-1:0]   winner
);

    logic [GW-1:0] idx;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path leaves it holding a value (no latch).
    always_comb begin
        valid  = 1'b0;
        winner = last_grant;
        idx    = '0;
        // Walk from the farthest offset down so the nearest requester is written last.
        for (int k = NREQ; k >= 1; k--) begin
            idx = GW'((int'(last_grant) + k) % NREQ);
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters,
// with optional ack timeout and a guaranteed idle cycle between requests.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NREQ        = NREQ_DEF,
    parameter  int DATA_W      = DATA_W_DEF,
    parameter  int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int GW          = $clog2(NREQ)
) (
    input  logic                   inclk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*DATA_W-1:0] data_i,
    output logic [NREQ-1:0]        ack_o,
    output logic [NREQ-1:0]        err_o,
    output logic                   uart_tx_req,
    output logic [DATA_W-1:0]      uart_tx_data,
    input  logic                   uart_tx_ack,
    output logic                   busy_o,
    output logic [GW-1:0]          grant_o
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic              tx_req_q, tx_req_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic              busy_q, busy_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              pick_valid;
    logic [GW-1:0]     pick_idx;
    logic [DATA_W-1:0] data_arr [NREQ];

    always_comb begin
        for (int n = 0; n < NREQ; n++) begin
            data_arr[n] = data_i[n*DATA_W +: DATA_W];
        end
    end

    rr_pick #(
        .NREQ(NREQ)
    ) u_rr_pick (
        .req       (req_i),
        .last_grant(last_grant_q),
        .valid     (pick_valid),
        .winner    (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        tx_req_d     = tx_req_q;
        tx_data_d    = tx_data_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        ack_d        = '0;
        err_d        = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = SEND;
                    tx_req_d  = 1'b1;
                    tx_data_d = data_arr[pick_idx];
                    grant_d   = pick_idx;
                    cnt_d     = '0;
                end
            end
            SEND: begin
                cnt_d = cnt_q + 16'd1;
                // Ack is tested first so it wins a tie with the timeout.
                if (uart_tx_ack) begin
                    state_d         = GAP;
                    tx_req_d        = 1'b0;
                    ack_d[grant_q]  = 1'b1;
                    last_grant_d    = grant_q;
                end else if (TIMEOUT_CYC != 0 && cnt_q == TO_LAST) begin
                    state_d         = GAP;
                    tx_req_d        = 1'b0;
                    err_d[grant_q]  = 1'b1;
                    last_grant_d    = grant_q;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                tx_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values and they all update together.
    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tx_req_q     <= 1'b0;
            tx_data_q    <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            busy_q       <= 1'b0;
            grant_q      <= '0;
            last_grant_q <= GW'(NREQ - 1);
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            tx_req_q     <= tx_req_d;
            tx_data_q    <= tx_data_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign uart_tx_req  = tx_req_q;
    assign uart_tx_data = tx_data_q;
    assign ack_o        = ack_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;
    assign grant_o      = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// transactions checked against a round-robin/timeout reference model.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic                   inclk = 1'b0;
    logic                   rst   = 1'b1;
    logic [NREQ-1:0]        req_i = '0;
    logic [NREQ*DATA_W-1:0] data_i = '0;
    logic [NREQ-1:0]        ack_o;
    logic [NREQ-1:0]        err_o;
    logic                   uart_tx_req;
    logic [DATA_W-1:0]      uart_tx_data;
    logic                   uart_tx_ack = 1'b0;
    logic                   busy_o;
    logic [1:0]             grant_o;

    int checks = 0;
    int errors = 0;
    int model_last = NREQ - 1;

    uart_tx_arbiter #(
        .NREQ       (NREQ),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .inclk       (inclk),
        .rst         (rst),
        .req_i       (req_i),
        .data_i      (data_i),
        .ack_o       (ack_o),
        .err_o       (err_o),
        .uart_tx_req (uart_tx_req),
        .uart_tx_data(uart_tx_data),
        .uart_tx_ack (uart_tx_ack),
        .busy_o      (busy_o),
        .grant_o     (grant_o)
    );

    always #5 inclk = ~inclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration rule: first requester after the last grant, wrapping.
    function automatic int rr_model(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge inclk);
        @(negedge inclk);
    endtask

    // One transaction entered from IDLE at a falling edge. The uart raises its
    // ack ack_delay cycles after uart_tx_req is first seen high.
    task automatic txn(input logic [NREQ-1:0] req, input int ack_delay,
                       input logic [NREQ-1:0] req_during);
        logic [NREQ*DATA_W-1:0] snap;
        logic [DATA_W-1:0]      exp_byte;
        int w, fin;
        bit acked;
        snap  = data_i;
        req_i = req;
        w     = rr_model(req, model_last);
        exp_byte = snap[w*DATA_W +: DATA_W];
        acked = (ack_delay <= TIMEOUT - 1);
        fin   = acked ? ack_delay + 1 : TIMEOUT;
        step();
        check("send_req",   uart_tx_req, 1);
        check("send_grant", grant_o, w);
        check("send_data",  uart_tx_data, exp_byte);
        check("send_busy",  busy_o, 1);
        req_i  = req_during;
        data_i = {$urandom()};
        for (int k = 0; k < fin; k++) begin
            if (k == ack_delay) uart_tx_ack = 1'b1;
            step();
            if (k + 1 < fin) begin
                check("hold_req",  uart_tx_req, 1);
                check("hold_data", uart_tx_data, exp_byte);
                check("hold_pulse", {ack_o, err_o}, 0);
            end
        end
        uart_tx_ack = 1'b0;
        check("done_req",  uart_tx_req, 0);
        check("done_ack",  ack_o, acked ? (1 << w) : 0);
        check("done_err",  err_o, acked ? 0 : (1 << w));
        check("gap_busy",  busy_o, 1);
        model_last = w;
        step();
        check("idle_pulse", {ack_o, err_o}, 0);
        check("idle_req",   uart_tx_req, 0);
        check("idle_busy",  busy_o, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge inclk);
        check("rst_req",   uart_tx_req, 0);
        check("rst_data",  uart_tx_data, 0);
        check("rst_pulse", {ack_o, err_o}, 0);
        check("rst_busy",  busy_o, 0);
        check("rst_grant", grant_o, 0);
        rst = 1'b0;

        // Single request, uart acks two cycles after the request
        data_i = 32'h0000_005A;
        txn(4'b0001, 2, 4'b0000);

        // Fairness with all four requesting
        data_i = 32'h1312_1110;
        for (int i = 0; i < 5; i++) begin
            data_i = 32'h1312_1110;
            txn(4'b1111, 1 + i, 4'b1111);
        end

        // Wrap-around from last grant 3
        data_i = 32'h0;
        txn(4'b1000, 0, 4'b0000);
        data_i = 32'hA300_00C0;
        txn(4'b1001, 3, 4'b1001);
        data_i = 32'hA300_00C0;
        txn(4'b1001, 3, 4'b0000);

        // Timeout with no ack, then ack on the timeout edge, then one edge earlier
        data_i = {$urandom()};
        txn(4'b0100, NEVER, 4'b0100);
        data_i = {$urandom()};
        txn(4'b0100, TIMEOUT - 1, 4'b0000);
        data_i = {$urandom()};
        txn(4'b0100, TIMEOUT - 2, 4'b0000);

        // Withdrawn request still completes
        data_i = {$urandom()};
        txn(4'b0010, 4, 4'b0000);

        // uart ack outside SEND is ignored
        req_i = '0;
        uart_tx_ack = 1'b1;
        repeat (3) begin
            step();
            check("stray_ack", {ack_o, err_o, uart_tx_req, busy_o}, 0);
        end
        uart_tx_ack = 1'b0;

        // Reset in the middle of SEND
        req_i = 4'b0010;
        step();
        check("pre_rst_req", uart_tx_req, 1);
        req_i = '0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_req",  uart_tx_req, 0);
        check("async_rst_busy", busy_o, 0);
        check("async_rst_pulse", {ack_o, err_o}, 0);
        @(negedge inclk);
        rst = 1'b0;
        model_last = NREQ - 1;
        step();
        check("post_rst_idle", {ack_o, err_o, uart_tx_req, busy_o}, 0);
        data_i = {$urandom()};
        txn(4'b0100, 1, 4'b0100);

        // Randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [NREQ-1:0] r;
            r = NREQ'($urandom_range(0, 15));
            data_i = {$urandom()};
            if (r == '0) begin
                req_i = '0;
                uart_tx_ack = 1'($urandom_range(0, 1));
                step();
                uart_tx_ack = 1'b0;
                check("rnd_idle", {ack_o, err_o, uart_tx_req, busy_o}, 0);
            end else begin
                txn(r, ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 17),
                    NREQ'($urandom_range(0, 15)));
            end
        end

        // Grant index after the random run follows the model's last grant
        req_i = '0;
        step();
        check("final_grant", grant_o, model_last);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
